// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: multi-lane write-back capture with stall/flush handling,
// same-beat lane conflict resolution and saturating retire/bubble counters.
module mem_wb_pipe #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int LANES         = 2,
  parameter int STALL_W       = 6,
  parameter int STALL_IDX     = 4,
  parameter int CNT_W         = 32,
  parameter int ZERO_SUPPRESS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STALL_W-1:0]        stall,
  input  logic                      flush,
  input  logic                      cnt_clear,
  input  logic                      mem_valid,
  input  logic [LANES*ADDR_W-1:0]   mem_wd,
  input  logic [LANES-1:0]          mem_wreg,
  input  logic [LANES*DATA_W-1:0]   mem_wdata,
  output logic                      wb_valid,
  output logic [LANES*ADDR_W-1:0]   wb_wd,
  output logic [LANES-1:0]          wb_wreg,
  output logic [LANES*DATA_W-1:0]   wb_wdata,
  output logic [CNT_W-1:0]          retire_cnt,
  output logic [CNT_W-1:0]          bubble_cnt
);

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_BUBBLE,
    ACT_HOLD
  } action_t;

  logic                     w_s;
  logic                     w_n;
  action_t                  w_act;
  logic [LANES-1:0]         w_wreg_zs;
  logic [LANES-1:0]         w_wreg_filt;
  logic                     w_retire_inc;
  logic                     w_bubble_inc;

  logic                     r_valid;
  logic [LANES*ADDR_W-1:0]  r_wd;
  logic [LANES-1:0]         r_wreg;
  logic [LANES*DATA_W-1:0]  r_wdata;
  logic [CNT_W-1:0]         r_retire_cnt;
  logic [CNT_W-1:0]         r_bubble_cnt;

  assign w_s = stall[STALL_IDX];
  assign w_n = stall[STALL_IDX+1];

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_act = ACT_ADVANCE;
    if (flush)             w_act = ACT_BUBBLE;
    else if (w_s && !w_n)  w_act = ACT_BUBBLE;
    else if (w_s && w_n)   w_act = ACT_HOLD;
  end

  always_comb begin
    w_wreg_zs = mem_wreg;
    for (int i = 0; i < LANES; i++) begin
      if (ZERO_SUPPRESS != 0 && mem_wd[i*ADDR_W +: ADDR_W] == '0) w_wreg_zs[i] = 1'b0;
    end
  end

  // A lower lane loses its enable when any higher enabled lane targets the same address.
  always_comb begin
    w_wreg_filt = w_wreg_zs;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (w_wreg_zs[i] && w_wreg_zs[j] &&
            mem_wd[i*ADDR_W +: ADDR_W] == mem_wd[j*ADDR_W +: ADDR_W])
          w_wreg_filt[i] = 1'b0;
      end
    end
  end

  assign w_retire_inc = (w_act == ACT_ADVANCE) && mem_valid;
  assign w_bubble_inc = (w_act == ACT_BUBBLE) || ((w_act == ACT_ADVANCE) && !mem_valid);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_wd    <= '0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else begin
      case (w_act)
        ACT_BUBBLE: begin
          r_valid <= 1'b0;
          r_wd    <= '0;
          r_wreg  <= '0;
          r_wdata <= '0;
        end
        ACT_ADVANCE: begin
          r_valid <= mem_valid;
          r_wd    <= mem_wd;
          r_wreg  <= mem_valid ? w_wreg_filt : '0;
          r_wdata <= mem_wdata;
        end
        default: ;
      endcase
    end
  end

  // Counters saturate at all-ones; a clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      r_retire_cnt <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_retire_inc && r_retire_cnt != '1) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      if (w_bubble_inc && r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign wb_valid   = r_valid;
  assign wb_wd      = r_wd;
  assign wb_wreg    = r_wreg;
  assign wb_wdata   = r_wdata;
  assign retire_cnt = r_retire_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe (LANES=2, CNT_W=4): expected wb_* values are queued
// when each step is driven and compared one cycle later.
module tb_mem_wb_pipe;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int LANES   = 2;
  localparam int STALL_W = 6;
  localparam int CNT_W   = 4;

  typedef struct packed {
    logic                    valid;
    logic [LANES*ADDR_W-1:0] wd;
    logic [LANES-1:0]        wreg;
    logic [LANES*DATA_W-1:0] wdata;
    logic [CNT_W-1:0]        retire;
    logic [CNT_W-1:0]        bubble;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [STALL_W-1:0]      stall;
  logic                    flush;
  logic                    cnt_clear;
  logic                    mem_valid;
  logic [LANES*ADDR_W-1:0] mem_wd;
  logic [LANES-1:0]        mem_wreg;
  logic [LANES*DATA_W-1:0] mem_wdata;
  logic                    wb_valid;
  logic [LANES*ADDR_W-1:0] wb_wd;
  logic [LANES-1:0]        wb_wreg;
  logic [LANES*DATA_W-1:0] wb_wdata;
  logic [CNT_W-1:0]        retire_cnt;
  logic [CNT_W-1:0]        bubble_cnt;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t model = '0;
  exp_t sb_q[$];

  mem_wb_pipe #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .STALL_W(STALL_W),
    .STALL_IDX(4), .CNT_W(CNT_W), .ZERO_SUPPRESS(1)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clear(cnt_clear),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Drive one cycle of stimulus; exp_we is the hand-derived conflict/zero-filtered enable.
  task automatic step(input string tag, input logic [5:0] st, input logic fl, input logic clr,
                      input logic r, input logic v, input logic [4:0] a0, input logic [4:0] a1,
                      input logic [1:0] we, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [1:0] exp_we);
    exp_t nxt;
    exp_t got;
    logic s, n;
    @(negedge clk);
    rst = r; stall = st; flush = fl; cnt_clear = clr;
    mem_valid = v; mem_wd = {a1, a0}; mem_wreg = we; mem_wdata = {d1, d0};
    s = st[4];
    n = st[5];
    nxt = model;
    if (r) begin
      nxt = '0;
    end else if (fl || (s && !n)) begin
      nxt.valid = 1'b0; nxt.wd = '0; nxt.wreg = '0; nxt.wdata = '0;
      nxt.bubble = sat_inc(model.bubble);
    end else if (!s) begin
      nxt.valid = v; nxt.wd = {a1, a0}; nxt.wdata = {d1, d0};
      nxt.wreg  = v ? exp_we : 2'b00;
      if (v) nxt.retire = sat_inc(model.retire);
      else   nxt.bubble = sat_inc(model.bubble);
    end
    if (clr && !r) begin
      nxt.retire = '0;
      nxt.bubble = '0;
    end
    model = nxt;
    sb_q.push_back(nxt);
    @(posedge clk);
    #1;
    n_vec++;
    assert (sb_q.size() > 0) else begin
      n_err++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      cmp({tag, ".valid"},  64'(wb_valid),   64'(got.valid));
      cmp({tag, ".wd"},     64'(wb_wd),      64'(got.wd));
      cmp({tag, ".wreg"},   64'(wb_wreg),    64'(got.wreg));
      cmp({tag, ".wdata"},  64'(wb_wdata),   64'(got.wdata));
      cmp({tag, ".retire"}, 64'(retire_cnt), 64'(got.retire));
      cmp({tag, ".bubble"}, 64'(bubble_cnt), 64'(got.bubble));
    end
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; cnt_clear = 1'b0;
    mem_valid = 1'b0; mem_wd = '0; mem_wreg = '0; mem_wdata = '0;

    step("rst0", 6'b000000, 0, 0, 1, 1, 5'd9, 5'd4, 2'b11, 32'h1111_1111, 32'h2222_2222, 2'b11);
    step("rst1", 6'b000000, 0, 0, 1, 1, 5'd9, 5'd4, 2'b11, 32'h1111_1111, 32'h2222_2222, 2'b11);
    step("adv",  6'b000000, 0, 0, 0, 1, 5'd3, 5'd0, 2'b01, 32'hDEAD_BEEF, 32'h0, 2'b01);
    cmp("adv.retire_is_1", 64'(retire_cnt), 64'd1);

    step("stall_bubble", 6'b011111, 0, 0, 0, 1, 5'd6, 5'd8, 2'b11, 32'hAAAA_0001, 32'hBBBB_0002, 2'b11);
    step("adv2", 6'b000000, 0, 0, 0, 1, 5'd12, 5'd13, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 2'b11);
    for (int k = 0; k < 3; k++)
      step("hold", 6'b111111, 0, 0, 0, 1, 5'd20, 5'd21, 2'b11, 32'hFFFF_0000 + 32'(k), 32'h5555_5555, 2'b11);
    cmp("hold.wdata_kept", 64'(wb_wdata), {32'h9ABC_DEF0, 32'h1234_5678});

    step("flush", 6'b000000, 1, 0, 0, 1, 5'd7, 5'd9, 2'b11, 32'hCAFE_0001, 32'hCAFE_0002, 2'b11);
    step("conflict", 6'b000000, 0, 0, 0, 1, 5'd7, 5'd7, 2'b11, 32'h0000_00A0, 32'h0000_00A1, 2'b10);
    step("zero_sup", 6'b000000, 0, 0, 0, 1, 5'd0, 5'd4, 2'b01, 32'h0000_00B0, 32'h0000_00B1, 2'b00);
    step("zero_hi",  6'b000000, 0, 0, 0, 1, 5'd7, 5'd0, 2'b11, 32'h0000_00C0, 32'h0000_00C1, 2'b01);
    step("inval",    6'b000000, 0, 0, 0, 0, 5'd5, 5'd0, 2'b01, 32'h0000_00D0, 32'h0, 2'b01);
    cmp("inval.wd_lane0", 64'(wb_wd[ADDR_W-1:0]), 64'd5);

    step("pre_hold",   6'b000000, 0, 0, 0, 1, 5'd10, 5'd11, 2'b11, 32'h0101_0101, 32'h0202_0202, 2'b11);
    step("hold_a",     6'b111111, 0, 0, 0, 1, 5'd1,  5'd2,  2'b11, 32'h0, 32'h0, 2'b11);
    step("hold_flush", 6'b111111, 1, 0, 0, 1, 5'd1,  5'd2,  2'b11, 32'h0, 32'h0, 2'b11);

    step("pre_rst", 6'b000000, 0, 0, 0, 1, 5'd14, 5'd15, 2'b11, 32'h7777_7777, 32'h8888_8888, 2'b11);
    step("mid_rst", 6'b000000, 0, 1, 1, 1, 5'd14, 5'd15, 2'b11, 32'h7777_7777, 32'h8888_8888, 2'b11);
    step("post_rst", 6'b000000, 0, 0, 0, 1, 5'd16, 5'd17, 2'b11, 32'h4444_4444, 32'h3333_3333, 2'b11);

    for (int k = 0; k < 17; k++)
      step("sat_ret", 6'b000000, 0, 0, 0, 1, 5'(1 + $urandom_range(30)), 5'($urandom_range(31)),
           2'b01, $urandom, $urandom, 2'b01);
    cmp("sat.retire_max", 64'(retire_cnt), 64'd15);

    step("clr_adv", 6'b000000, 0, 1, 0, 1, 5'd19, 5'd18, 2'b11, 32'h600D_F00D, 32'hBAD0_0BAD, 2'b11);
    cmp("clr.retire_zero", 64'(retire_cnt), 64'd0);

    for (int k = 0; k < 16; k++)
      step("sat_bub", 6'b000000, 0, 0, 0, 0, 5'($urandom_range(31)), 5'($urandom_range(31)),
           2'b11, $urandom, $urandom, 2'b00);
    cmp("sat.bubble_max", 64'(bubble_cnt), 64'd15);

    step("clr_sat", 6'b011111, 0, 1, 0, 1, 5'd3, 5'd4, 2'b11, 32'h1, 32'h2, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM/WB pipeline register: captures up to LANES write-back channels (general registers plus optional HI/LO or other side channels) from the memory stage and presents them to write-back one cycle later. It supports the 6-bit stall vector, a flush input for exceptions, and same-beat lane conflict resolution. It also keeps saturating retire and bubble counters for performance monitoring. It replaces the single-lane MEM/WB register between the memory-access stage and the register file.

## Interface
Parameters:
- DATA_W, 32, width of one lane's write data
- ADDR_W, 5, width of one lane's destination address
- LANES, 2, number of write-back lanes (≥1)
- STALL_W, 6, width of stall vector
- STALL_IDX, 4, stall bit owned by this stage; STALL_IDX+1 is the downstream stage (STALL_IDX+1 < STALL_W)
- CNT_W, 32, counter width
- ZERO_SUPPRESS, 1, when 1, a lane addressed to 0 never asserts write enable

Ports:
- clk, in, 1, clock; all state updates on rising edge
- rst, in, 1, synchronous, active-high reset
- stall, in, STALL_W, per-stage stop flags (1 = stop)
- flush, in, 1, discard the incoming instruction and load a bubble
- cnt_clear, in, 1, synchronous clear of both counters
- mem_valid, in, 1, the memory-stage slot holds a real instruction
- mem_wd, in, LANES*ADDR_W, lane i destination address at bits [i*ADDR_W +: ADDR_W]
- mem_wreg, in, LANES, per-lane write enable
- mem_wdata, in, LANES*DATA_W, per-lane write data
- wb_valid, out, 1, registered valid
- wb_wd, out, LANES*ADDR_W, registered addresses
- wb_wreg, out, LANES, registered, conflict-resolved write enables
- wb_wdata, out, LANES*DATA_W, registered data
- retire_cnt, out, CNT_W, number of real instructions passed to WB
- bubble_cnt, out, CNT_W, number of bubbles loaded into WB

## Operation
- Definitions: s = stall[STALL_IDX], n = stall[STALL_IDX+1].
- Per-edge action, in strict priority:
  1. rst: all outputs go to 0, including both counters.
  2. flush: load a bubble.
  3. s=1 and n=0: load a bubble.
  4. s=1 and n=1: hold. All registers keep their value and both counters are unchanged.
  5. Otherwise (s=0): advance.
- Bubble: wb_valid=0, wb_wd=0, wb_wreg=0, wb_wdata=0.
- Advance:
  - wb_valid ← mem_valid.
  - wb_wd and wb_wdata ← their inputs.
  - wb_wreg ← mem_wreg after filtering, gated by mem_valid. With mem_valid=0, wb_wreg=0 but wd/wdata are still captured.
- Lane filtering (combinational, before capture):
  - ZERO_SUPPRESS=1 and a lane's address is 0: that lane's enable is cleared.
  - Two or more enabled lanes with equal address: only the highest-index lane keeps its enable; lower ones are cleared. Their data is still captured unchanged.
- retire_cnt: +1 on an advance with mem_valid=1.
- bubble_cnt: +1 on any bubble load (flush or case 3), or on an advance with mem_valid=0.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- cnt_clear=1 sets both counters to 0 and overrides any increment in the same cycle. It does not affect the pipeline registers. rst has priority over cnt_clear.

## Timing
- Latency: exactly 1 cycle from mem_* to wb_* on advance. There is no combinational path from inputs to outputs.
- Counters are registered and reflect the edge that updated wb_*.
- Hold may persist any number of cycles; outputs stay constant throughout.
- Flush during hold (s=n=1, flush=1): a bubble is loaded and bubble_cnt increments. The held instruction is lost by design.
- Reset asserted mid-hold or mid-stream: outputs are 0 on the next edge. Inputs are sampled normally starting from the first edge after rst deasserts.
- Counter at max with an increment event: the value stays at max.
- Counter at max with cnt_clear: the value becomes 0.

## Test plan
- Reset then advance: assert rst for 2 cycles, then apply mem_valid=1, lane0 wd=3, wreg=1, wdata=0xDEADBEEF.
  - All outputs read 0 during reset.
  - On the next edge: wb_wd[lane0]=3, wb_wreg=01, wb_wdata=0xDEADBEEF, retire_cnt=1.
- Stall cases: set stall=6'b011111 (s=1, n=0).
  - Result: bubble loaded, wb_wreg=0, bubble_cnt+1.
  - Then set stall=6'b111111 for 3 cycles: wb_* unchanged from the prior edge and both counters frozen.
- Flush priority: flush=1 together with s=0 and a valid input.
  - Result: bubble loaded, retire_cnt unchanged, bubble_cnt+1.
- Lane conflict and zero suppression, with LANES=2:
  - Both lanes at wd=7 with wreg=11: wb_wreg=10.
  - Lane0 wd=0, wreg=01: wb_wreg=00.
  - Lane1 wd=0 and lane0 wd=7 (wreg=11): wb_wreg=01.
- Counter saturation, with CNT_W=4:
  - Perform 17 valid advances: retire_cnt=15.
  - cnt_clear together with a valid advance: retire_cnt=0 and the wb_* data is captured.
- mem_valid=0 advance with wreg=01 and wd=5: wb_valid=0, wb_wreg=00, wb_wd[lane0]=5, bubble_cnt+1.
